// File: rtl/warp_issue_sched.sv
// Per-core warp scheduler: tracks active/stalled/tmask/PC per warp and issues
// one ready warp per cycle round-robin to fetch over a valid/ready handshake.
module warp_issue_sched #(
  parameter int unsigned         NUM_WARPS   = 4,
  parameter int unsigned         NUM_THREADS = 4,
  parameter int unsigned         PC_BITS     = 30,
  parameter logic [PC_BITS-1:0]  START_PC    = 30'h0800_0000,
  parameter int unsigned         NW_WIDTH    = $clog2(NUM_WARPS)
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   sched_valid,
  input  logic                   sched_ready,
  output logic [NW_WIDTH-1:0]    sched_wid,
  output logic [PC_BITS-1:0]     sched_pc,
  output logic [NUM_THREADS-1:0] sched_tmask,
  input  logic                   sched_stall,
  input  logic                   wctl_valid,
  input  logic [NW_WIDTH-1:0]    wctl_wid,
  input  logic                   wctl_tmc,
  input  logic [NUM_THREADS-1:0] wctl_tmask,
  input  logic                   wctl_br_taken,
  input  logic [PC_BITS-1:0]     wctl_br_pc,
  input  logic                   wspawn_valid,
  input  logic [NUM_WARPS-1:0]   wspawn_mask,
  input  logic [PC_BITS-1:0]     wspawn_pc,
  output logic [NUM_WARPS-1:0]   active_warps,
  output logic [NUM_WARPS-1:0]   stalled_warps,
  output logic                   busy
);

  logic [PC_BITS-1:0]     pc_q    [NUM_WARPS];
  logic [NUM_THREADS-1:0] tmask_q [NUM_WARPS];
  logic [NW_WIDTH-1:0]    rr_ptr;

  logic [PC_BITS-1:0]     pc_n    [NUM_WARPS];
  logic [NUM_THREADS-1:0] tmask_n [NUM_WARPS];
  logic [NUM_WARPS-1:0]   active_n;
  logic [NUM_WARPS-1:0]   stalled_n;
  logic [NUM_WARPS-1:0]   ready_n;
  logic [NUM_WARPS-1:0]   spawn_set;
  logic [NW_WIDTH-1:0]    rr_n;
  logic [NW_WIDTH-1:0]    sel;
  logic [NW_WIDTH-1:0]    cand;
  logic                   found;
  logic                   fire;
  logic                   lock;

  assign fire = sched_valid & sched_ready;
  assign lock = sched_valid & ~sched_ready;
  assign busy = |active_warps;

  // Warp 0 can never be spawned; only warps currently inactive accept a spawn.
  assign spawn_set = wspawn_valid ? (wspawn_mask & ~active_warps & ~NUM_WARPS'(1)) : '0;

  always_comb begin
    active_n  = active_warps;
    stalled_n = stalled_warps;
    pc_n      = pc_q;
    tmask_n   = tmask_q;
    rr_n      = rr_ptr;

    if (fire) begin
      rr_n            = sched_wid;
      pc_n[sched_wid] = pc_q[sched_wid] + 1'b1;
      if (sched_stall) stalled_n[sched_wid] = 1'b1;
    end

    // Warp control only acts on a warp that was stalled when sampled.
    if (wctl_valid && stalled_warps[wctl_wid]) begin
      stalled_n[wctl_wid] = 1'b0;
      if (wctl_tmc) begin
        tmask_n[wctl_wid] = wctl_tmask;
        if (wctl_tmask == '0) active_n[wctl_wid] = 1'b0;
      end
      if (wctl_br_taken) pc_n[wctl_wid] = wctl_br_pc;
    end

    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      if (spawn_set[i]) begin
        active_n[i]  = 1'b1;
        stalled_n[i] = 1'b0;
        pc_n[i]      = wspawn_pc;
        tmask_n[i]   = '1;
      end
    end
  end

  // Selection looks at post-update state so a lone unstalled warp can issue
  // back-to-back with its incremented PC.
  always_comb begin
    ready_n = active_n & ~stalled_n;
    found   = 1'b0;
    sel     = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_WARPS; k++) begin
      cand = rr_n + NW_WIDTH'(k);
      if (!found && ready_n[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_warps  <= NUM_WARPS'(1);
      stalled_warps <= '0;
      rr_ptr        <= '0;
      for (int unsigned i = 0; i < NUM_WARPS; i++) begin
        pc_q[i]    <= START_PC;
        tmask_q[i] <= (i == 0) ? NUM_THREADS'(1) : '0;
      end
    end else begin
      active_warps  <= active_n;
      stalled_warps <= stalled_n;
      rr_ptr        <= rr_n;
      pc_q          <= pc_n;
      tmask_q       <= tmask_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sched_valid <= 1'b0;
      sched_wid   <= '0;
      sched_pc    <= '0;
      sched_tmask <= '0;
    end else if (!lock) begin
      sched_valid <= found;
      sched_wid   <= sel;
      sched_pc    <= pc_n[sel];
      sched_tmask <= tmask_n[sel];
    end
  end

endmodule

// File: tb/tb_warp_issue_sched.sv
// Bench for warp_issue_sched: directed vector table, async-reset sequence and
// randomized traffic checked against a per-warp behavioural model.
module tb_warp_issue_sched;
  localparam int NW = 4;
  localparam int NT = 4;
  localparam int PCB = 30;
  localparam logic [PCB-1:0] SPC = 30'h0800_0000;

  logic clk, reset;
  logic sched_valid, sched_ready, sched_stall;
  logic [1:0] sched_wid;
  logic [PCB-1:0] sched_pc;
  logic [NT-1:0] sched_tmask;
  logic wctl_valid, wctl_tmc, wctl_br_taken;
  logic [1:0] wctl_wid;
  logic [NT-1:0] wctl_tmask;
  logic [PCB-1:0] wctl_br_pc;
  logic wspawn_valid;
  logic [NW-1:0] wspawn_mask;
  logic [PCB-1:0] wspawn_pc;
  logic [NW-1:0] active_warps, stalled_warps;
  logic busy;

  int n_cmp = 0;
  int n_bad = 0;

  warp_issue_sched #(.NUM_WARPS(NW), .NUM_THREADS(NT), .PC_BITS(PCB), .START_PC(SPC)) dut (
    .clk(clk), .reset(reset),
    .sched_valid(sched_valid), .sched_ready(sched_ready), .sched_wid(sched_wid),
    .sched_pc(sched_pc), .sched_tmask(sched_tmask), .sched_stall(sched_stall),
    .wctl_valid(wctl_valid), .wctl_wid(wctl_wid), .wctl_tmc(wctl_tmc),
    .wctl_tmask(wctl_tmask), .wctl_br_taken(wctl_br_taken), .wctl_br_pc(wctl_br_pc),
    .wspawn_valid(wspawn_valid), .wspawn_mask(wspawn_mask), .wspawn_pc(wspawn_pc),
    .active_warps(active_warps), .stalled_warps(stalled_warps), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit ready, stall;
    bit wc_v; int wc_wid; bit wc_tmc; logic [NT-1:0] wc_tm; bit wc_br; logic [PCB-1:0] wc_pc;
    bit sp_v; logic [NW-1:0] sp_mask; logic [PCB-1:0] sp_pc;
    bit ev; int ewid; logic [PCB-1:0] epc; logic [NT-1:0] etm;
    logic [NW-1:0] eact, estl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit s, bit ev, int ewid, logic [PCB-1:0] epc,
                              logic [NT-1:0] etm, logic [NW-1:0] eact, logic [NW-1:0] estl);
    vec_t v;
    v.ready = r; v.stall = s;
    v.wc_v = 0; v.wc_wid = 0; v.wc_tmc = 0; v.wc_tm = '0; v.wc_br = 0; v.wc_pc = '0;
    v.sp_v = 0; v.sp_mask = '0; v.sp_pc = '0;
    v.ev = ev; v.ewid = ewid; v.epc = epc; v.etm = etm; v.eact = eact; v.estl = estl;
    return v;
  endfunction

  function automatic vec_t wc(vec_t v, int wid, bit tmc, logic [NT-1:0] tm, bit br, logic [PCB-1:0] pc);
    v.wc_v = 1; v.wc_wid = wid; v.wc_tmc = tmc; v.wc_tm = tm; v.wc_br = br; v.wc_pc = pc;
    return v;
  endfunction

  function automatic vec_t sp(vec_t v, logic [NW-1:0] mask, logic [PCB-1:0] pc);
    v.sp_v = 1; v.sp_mask = mask; v.sp_pc = pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    sched_ready = v.ready; sched_stall = v.stall;
    wctl_valid = v.wc_v; wctl_wid = 2'(v.wc_wid); wctl_tmc = v.wc_tmc;
    wctl_tmask = v.wc_tm; wctl_br_taken = v.wc_br; wctl_br_pc = v.wc_pc;
    wspawn_valid = v.sp_v; wspawn_mask = v.sp_mask; wspawn_pc = v.sp_pc;
  endtask

  task automatic apply(input vec_t v, input string tag);
    drive(v);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 64'(sched_valid), 64'(v.ev));
    if (v.ev) begin
      chk({tag, "_wid"}, 64'(sched_wid), 64'(v.ewid));
      chk({tag, "_pc"}, 64'(sched_pc), 64'(v.epc));
      chk({tag, "_tmask"}, 64'(sched_tmask), 64'(v.etm));
    end
    chk({tag, "_active"}, 64'(active_warps), 64'(v.eact));
    chk({tag, "_stalled"}, 64'(stalled_warps), 64'(v.estl));
    chk({tag, "_busy"}, 64'(busy), 64'(|v.eact));
  endtask

  // Behavioural model: per-warp arrays plus the expected presented selection.
  bit m_act[NW], m_stl[NW];
  logic [PCB-1:0] m_pc[NW];
  logic [NT-1:0] m_tm[NW];
  int m_rr;
  bit e_valid; int e_wid; logic [PCB-1:0] e_pc; logic [NT-1:0] e_tm;

  task automatic model_reset();
    for (int i = 0; i < NW; i++) begin
      m_act[i] = (i == 0); m_stl[i] = 0; m_pc[i] = SPC; m_tm[i] = (i == 0) ? NT'(1) : '0;
    end
    m_rr = 0; e_valid = 0; e_wid = 0; e_pc = '0; e_tm = '0;
  endtask

  task automatic model_step();
    bit a0[NW];
    bit s0[NW];
    bit fire, hold;
    a0 = m_act; s0 = m_stl;
    fire = e_valid && sched_ready;
    hold = e_valid && !sched_ready;
    if (fire) begin
      m_rr = e_wid;
      m_pc[e_wid] = m_pc[e_wid] + 1;
      if (sched_stall) m_stl[e_wid] = 1;
    end
    if (wctl_valid && s0[wctl_wid]) begin
      m_stl[wctl_wid] = 0;
      if (wctl_tmc) begin
        m_tm[wctl_wid] = wctl_tmask;
        if (wctl_tmask == 0) m_act[wctl_wid] = 0;
      end
      if (wctl_br_taken) m_pc[wctl_wid] = wctl_br_pc;
    end
    if (wspawn_valid)
      for (int i = 1; i < NW; i++)
        if (wspawn_mask[i] && !a0[i]) begin
          m_act[i] = 1; m_stl[i] = 0; m_pc[i] = wspawn_pc; m_tm[i] = '1;
        end
    if (!hold) begin
      e_valid = 0;
      for (int k = 1; k <= NW; k++) begin
        int w;
        w = (m_rr + k) % NW;
        if (!e_valid && m_act[w] && !m_stl[w]) begin
          e_valid = 1; e_wid = w; e_pc = m_pc[w]; e_tm = m_tm[w];
        end
      end
    end
  endtask

  function automatic logic [NW-1:0] pack(bit b[NW]);
    logic [NW-1:0] r;
    for (int i = 0; i < NW; i++) r[i] = b[i];
    return r;
  endfunction

  initial begin
    vec_t v;
    reset = 1'b0;
    drive(mk(0, 0, 0, 0, '0, '0, '0, '0));
    #12;
    chk("rst_valid", 64'(sched_valid), 64'(0));
    chk("rst_active", 64'(active_warps), 64'(1));
    chk("rst_stalled", 64'(stalled_warps), 64'(0));
    chk("rst_busy", 64'(busy), 64'(1));
    reset = 1'b1;

    vecs.push_back(mk(1, 0, 1, 0, SPC,     4'h1, 4'h1, 4'h0));
    vecs.push_back(mk(1, 0, 1, 0, SPC + 1, 4'h1, 4'h1, 4'h0));
    vecs.push_back(sp(mk(1, 0, 1, 1, 30'h100, 4'hf, 4'hf, 4'h0), 4'b1110, 30'h100));
    vecs.push_back(mk(1, 0, 1, 2, 30'h100, 4'hf, 4'hf, 4'h0));
    vecs.push_back(mk(1, 0, 1, 3, 30'h100, 4'hf, 4'hf, 4'h0));
    vecs.push_back(mk(1, 0, 1, 0, SPC + 2, 4'h1, 4'hf, 4'h0));
    vecs.push_back(mk(1, 0, 1, 1, 30'h101, 4'hf, 4'hf, 4'h0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 1, 1, 30'h101, 4'hf, 4'hf, 4'h0));
    vecs.push_back(mk(1, 0, 1, 2, 30'h101, 4'hf, 4'hf, 4'h0));
    vecs.push_back(mk(1, 1, 1, 3, 30'h101, 4'hf, 4'hf, 4'b0100));
    vecs.push_back(mk(1, 0, 1, 0, SPC + 3, 4'h1, 4'hf, 4'b0100));
    vecs.push_back(mk(1, 0, 1, 1, 30'h102, 4'hf, 4'hf, 4'b0100));
    vecs.push_back(wc(mk(1, 0, 1, 2, 30'h40, 4'hf, 4'hf, 4'h0), 2, 0, '0, 1, 30'h40));
    vecs.push_back(mk(1, 1, 1, 3, 30'h102, 4'hf, 4'hf, 4'b0100));
    vecs.push_back(wc(mk(0, 0, 1, 3, 30'h102, 4'hf, 4'hf, 4'b0100), 3, 1, '0, 0, '0));
    vecs.push_back(mk(1, 0, 1, 0, SPC + 4, 4'h1, 4'hf, 4'b0100));
    vecs.push_back(mk(1, 1, 1, 1, 30'h103, 4'hf, 4'hf, 4'b0101));
    vecs.push_back(mk(1, 1, 1, 3, 30'h103, 4'hf, 4'hf, 4'b0111));
    vecs.push_back(wc(mk(1, 1, 0, 0, '0, '0, 4'b1101, 4'b1101), 1, 1, '0, 0, '0));
    vecs.push_back(wc(mk(1, 0, 0, 0, '0, '0, 4'b1100, 4'b1100), 0, 1, '0, 0, '0));
    vecs.push_back(wc(mk(1, 0, 0, 0, '0, '0, 4'b1000, 4'b1000), 2, 1, '0, 0, '0));
    vecs.push_back(wc(mk(1, 0, 0, 0, '0, '0, 4'b0000, 4'b0000), 3, 1, '0, 0, '0));
    vecs.push_back(sp(mk(1, 0, 1, 1, 30'h200, 4'hf, 4'b0010, 4'h0), 4'b0011, 30'h200));
    vecs.push_back(mk(1, 0, 1, 1, 30'h201, 4'hf, 4'b0010, 4'h0));
    vecs.push_back(mk(0, 0, 1, 1, 30'h201, 4'hf, 4'b0010, 4'h0));

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Reset while a selection is held: outputs must drop before any clock edge.
    sched_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", 64'(sched_valid), 64'(0));
    chk("arst_active", 64'(active_warps), 64'(1));
    chk("arst_stalled", 64'(stalled_warps), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    apply(mk(1, 0, 1, 0, SPC,     4'h1, 4'h1, 4'h0), "arst_first");
    apply(mk(1, 0, 1, 0, SPC + 1, 4'h1, 4'h1, 4'h0), "arst_second");

    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      v = mk($urandom_range(3) != 0, $urandom_range(3) == 0, 0, 0, '0, '0, '0, '0);
      if ($urandom_range(2) == 0)
        v = wc(v, int'($urandom_range(NW - 1)), $urandom_range(3) == 0,
               ($urandom_range(2) == 0) ? NT'(0) : NT'($urandom), $urandom_range(1) == 1,
               PCB'($urandom));
      if ($urandom_range(7) == 0) v = sp(v, NW'($urandom), PCB'($urandom));
      drive(v);
      @(posedge clk);
      model_step();
      #1;
      chk("rnd_valid", 64'(sched_valid), 64'(e_valid));
      if (e_valid) begin
        chk("rnd_wid", 64'(sched_wid), 64'(e_wid));
        chk("rnd_pc", 64'(sched_pc), 64'(e_pc));
        chk("rnd_tmask", 64'(sched_tmask), 64'(e_tm));
      end
      chk("rnd_active", 64'(active_warps), 64'(pack(m_act)));
      chk("rnd_stalled", 64'(stalled_warps), 64'(pack(m_stl)));
      chk("rnd_busy", 64'(busy), 64'(|pack(m_act)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
